// File: rtl/dac_sine_source_if.sv
// Bundles the control inputs and sample outputs of the DAC sine source.
//   master : controller side; drives enable/ptos_x_ciclo/seleccion_dac,
//            receives data/data_valid/zero_cross/busy
//   slave  : generator side (dac_sine_source)
interface dac_sine_source_if;
  logic        enable;
  logic [15:0] ptos_x_ciclo;
  logic        seleccion_dac;
  logic [13:0] data;
  logic        data_valid;
  logic        zero_cross;
  logic        busy;

  modport master (
    output enable, ptos_x_ciclo, seleccion_dac,
    input  data, data_valid, zero_cross, busy
  );

  modport slave (
    input  enable, ptos_x_ciclo, seleccion_dac,
    output data, data_valid, zero_cross, busy
  );
endinterface

// File: rtl/dac_sine_source.sv
// Sample generator for the DAC output stage: one 14-bit offset-binary sample per clock.
// Emits an exact-period sine of P samples read from a ROM, or a constant level. The
// per-sample table step q = LutDepth / P and remainder r are found once by a 16-cycle
// restoring divider; a Bresenham accumulator then keeps addr(n) = floor(n * LutDepth / P).
//
// Ports:
//   clock   in  system clock, rising edge
//   reset   in  synchronous active-high reset
//   dac_io  slave modport of dac_sine_source_if:
//           enable (start in idle / stop request in run), ptos_x_ciclo (P), seleccion_dac
//           (0 sine, 1 constant) in; data, data_valid, zero_cross, busy out.
//
// Build option: define QUARTER_WAVE_EN to store only a quarter wave (LutDepth/4+1 entries)
// and fold the address at run time; output and latency are identical to the full table.
module dac_sine_source #(
  parameter int unsigned LutAw      = 10,
  parameter int unsigned MidLevel   = 8192,
  parameter int unsigned ConstLevel = 12288,
  parameter int unsigned MinPtos    = 4
) (
  input  logic             clock,
  input  logic             reset,
  dac_sine_source_if.slave dac_io
);

  localparam int unsigned LutDepth = 2 ** LutAw;
  localparam int unsigned QtrDepth = LutDepth / 4;
  localparam int unsigned FixBits  = 30;
  localparam longint      PiFix    = 64'sd3373259426;  // round(pi * 2^30)

  // round(MidLevel + 8191 * sin(2*pi*k/LutDepth)) for k in the first quadrant,
  // evaluated at elaboration with a fixed-point Taylor series.
  function automatic logic [13:0] quarter_val(int unsigned k);
    longint x, x2, term, s;
    x    = (PiFix * longint'(k)) / longint'(LutDepth / 2);
    x2   = (x * x) >>> FixBits;
    term = x;
    s    = x;
    for (int i = 1; i <= 8; i++) begin
      term = -((term * x2) / (longint'(2 * i * (2 * i + 1)) <<< FixBits));
      s    = s + term;
    end
    if (s < 0) s = 0;
    return 14'(longint'(MidLevel) + ((64'sd8191 * s + (64'sd1 <<< (FixBits - 1))) >>> FixBits));
  endfunction

  function automatic logic [13:0] full_val(int unsigned k);
    int unsigned quad, off;
    logic [13:0] v;
    quad = k / QtrDepth;
    off  = k % QtrDepth;
    v    = quarter_val(quad[0] ? QtrDepth - off : off);
    return quad[1] ? 14'(32'd16384 - 32'(v)) : v;
  endfunction

  typedef enum logic [1:0] {StIdle, StDiv, StRun, StFinish} state_e;

  state_e            state_q;
  logic              busy_q, sel_q;
  logic [15:0]       p_q, dvd_q, rem_q, n_q, err_q;
  logic [4:0]        cnt_q;
  logic [LutAw-1:0]  addr_q;

  logic [15:0]       p_start;
  logic [16:0]       rem_sh, err_sum;
  logic              rem_ge, wrap, last, active;
  logic [15:0]       err_d;
  logic [LutAw-1:0]  addr_d;

  // After the divide, dvd_q holds the quotient q and rem_q the remainder r.
  always_comb begin
    p_start = (dac_io.ptos_x_ciclo < 16'(MinPtos)) ? 16'(MinPtos) : dac_io.ptos_x_ciclo;
    rem_sh  = {rem_q, dvd_q[15]};
    rem_ge  = rem_sh >= {1'b0, p_q};
    err_sum = {1'b0, err_q} + {1'b0, rem_q};
    wrap    = err_sum >= {1'b0, p_q};
    err_d   = wrap ? 16'(err_sum - {1'b0, p_q}) : err_sum[15:0];
    addr_d  = addr_q + dvd_q[LutAw-1:0] + LutAw'(wrap);
    last    = n_q == p_q - 16'd1;
    active  = (state_q == StRun) || (state_q == StFinish);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      sel_q   <= 1'b0;
      p_q     <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      err_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dac_io.enable) begin
            state_q <= StDiv;
            busy_q  <= 1'b1;
            p_q     <= p_start;
            sel_q   <= dac_io.seleccion_dac;
            dvd_q   <= 16'(LutDepth);
            rem_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StDiv: begin
          if (cnt_q == 5'd16) begin
            state_q <= StRun;
            n_q     <= '0;
            addr_q  <= '0;
            err_q   <= '0;
          end else begin
            dvd_q <= {dvd_q[14:0], rem_ge};
            rem_q <= rem_ge ? 16'(rem_sh - {1'b0, p_q}) : rem_sh[15:0];
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StRun, StFinish: begin
          if (last) begin
            n_q    <= '0;
            addr_q <= '0;
            err_q  <= '0;
          end else begin
            n_q    <= n_q + 16'd1;
            addr_q <= addr_d;
            err_q  <= err_d;
          end
          // A stop request finishes the current period; enable is not re-checked in finish.
          if (last && (state_q == StFinish || !dac_io.enable)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (!dac_io.enable) begin
            state_q <= StFinish;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [13:0] rom_rd;
  logic        rd_neg;

`ifdef QUARTER_WAVE_EN
  logic [13:0]      rom [QtrDepth + 1];
  logic [LutAw-2:0] qidx;

  for (genvar g = 0; g <= QtrDepth; g++) begin : g_rom
    localparam logic [13:0] RomVal = quarter_val(g);
    assign rom[g] = RomVal;
  end

  // Odd quadrants read the table backwards; the second half mirrors about mid-scale.
  always_comb begin
    qidx   = addr_q[LutAw-2] ? (LutAw-1)'(QtrDepth) - {1'b0, addr_q[LutAw-3:0]}
                             : {1'b0, addr_q[LutAw-3:0]};
    rom_rd = rom[qidx];
    rd_neg = addr_q[LutAw-1];
  end
`else
  logic [13:0] rom [LutDepth];

  for (genvar g = 0; g < LutDepth; g++) begin : g_rom
    localparam logic [13:0] RomVal = full_val(g);
    assign rom[g] = RomVal;
  end

  always_comb begin
    rom_rd = rom[addr_q];
    rd_neg = 1'b0;
  end
`endif

  logic [13:0] rom_q, data_q, sine_val;
  logic        v1_q, zc1_q, neg1_q, valid_q, zc_q;

  assign sine_val = neg1_q ? 14'(15'd16384 - {1'b0, rom_q}) : rom_q;

  // Stage 1: registered ROM read; stage 2: output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rom_q   <= 14'(MidLevel);
      neg1_q  <= 1'b0;
      v1_q    <= 1'b0;
      zc1_q   <= 1'b0;
      data_q  <= 14'(MidLevel);
      valid_q <= 1'b0;
      zc_q    <= 1'b0;
    end else begin
      rom_q   <= rom_rd;
      neg1_q  <= rd_neg;
      v1_q    <= active;
      zc1_q   <= active && (n_q == '0);
      data_q  <= !v1_q ? 14'(MidLevel) : (sel_q ? 14'(ConstLevel) : sine_val);
      valid_q <= v1_q;
      zc_q    <= v1_q && zc1_q;
    end
  end

  assign dac_io.data       = data_q;
  assign dac_io.data_valid = valid_q;
  assign dac_io.zero_cross = zc_q;
  assign dac_io.busy       = busy_q;

endmodule
